// File: rtl/demux_1_2_stream_if.sv
// Stream bundle for the 1:2 byte demux: one input stream (s_*), two output streams (x_*, y_*).
// Beat counters exist only when DEMUX_CNT_EN is defined.
interface demux_1_2_stream_if #(
   parameter int unsigned WIDTH = 8
`ifdef DEMUX_CNT_EN
   , parameter int unsigned CNT_W = 16
`endif
);
   logic             sel;
   logic             s_valid;
   logic             s_ready;
   logic [WIDTH-1:0] s_data;
   logic             x_valid;
   logic             x_ready;
   logic [WIDTH-1:0] x_data;
   logic             y_valid;
   logic             y_ready;
   logic [WIDTH-1:0] y_data;
`ifdef DEMUX_CNT_EN
   logic [CNT_W-1:0] x_count;
   logic [CNT_W-1:0] y_count;

   modport master (
      output sel, s_valid, s_data, x_ready, y_ready,
      input  s_ready, x_valid, x_data, y_valid, y_data, x_count, y_count
   );
   modport slave (
      input  sel, s_valid, s_data, x_ready, y_ready,
      output s_ready, x_valid, x_data, y_valid, y_data, x_count, y_count
   );
`else
   modport master (
      output sel, s_valid, s_data, x_ready, y_ready,
      input  s_ready, x_valid, x_data, y_valid, y_data
   );
   modport slave (
      input  sel, s_valid, s_data, x_ready, y_ready,
      output s_ready, x_valid, x_data, y_valid, y_data
   );
`endif
endinterface

// File: rtl/demux_1_2_stream.sv
// Registered 1:2 byte-stream demux with a 1-entry holding register per output.
// Define DEMUX_CNT_EN to add wrapping per-output delivered-beat counters.
module demux_1_2_stream #(
   parameter int unsigned WIDTH = 8
`ifdef DEMUX_CNT_EN
   , parameter int unsigned CNT_W = 16
`endif
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   demux_1_2_stream_if.slave bus
);
   logic             r_x_valid;
   logic [WIDTH-1:0] r_x_data;
   logic             r_y_valid;
   logic [WIDTH-1:0] r_y_data;

   logic w_free_x;
   logic w_free_y;
   logic w_accept;
   logic w_load_x;
   logic w_load_y;
   logic w_drain_x;
   logic w_drain_y;

   // A slot is free if empty or being drained this cycle, allowing 1 beat/cycle.
   assign w_free_x  = ~r_x_valid | bus.x_ready;
   assign w_free_y  = ~r_y_valid | bus.y_ready;
   assign w_accept  = bus.s_valid & bus.s_ready;
   assign w_load_x  = w_accept & ~bus.sel;
   assign w_load_y  = w_accept &  bus.sel;
   assign w_drain_x = r_x_valid & bus.x_ready;
   assign w_drain_y = r_y_valid & bus.y_ready;

   assign bus.s_ready = bus.sel ? w_free_y : w_free_x;
   assign bus.x_valid = r_x_valid;
   assign bus.x_data  = r_x_data;
   assign bus.y_valid = r_y_valid;
   assign bus.y_data  = r_y_data;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_x_valid <= 1'b0;
         r_x_data  <= '0;
      end else if (w_load_x) begin
         r_x_valid <= 1'b1;
         r_x_data  <= bus.s_data;
      end else if (w_drain_x) begin
         r_x_valid <= 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_y_valid <= 1'b0;
         r_y_data  <= '0;
      end else if (w_load_y) begin
         r_y_valid <= 1'b1;
         r_y_data  <= bus.s_data;
      end else if (w_drain_y) begin
         r_y_valid <= 1'b0;
      end
   end

`ifdef DEMUX_CNT_EN
   logic [CNT_W-1:0] r_x_count;
   logic [CNT_W-1:0] r_y_count;

   // Counters wrap naturally at 2^CNT_W.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_x_count <= '0;
         r_y_count <= '0;
      end else begin
         if (w_drain_x) r_x_count <= r_x_count + 1'b1;
         if (w_drain_y) r_y_count <= r_y_count + 1'b1;
      end
   end

   assign bus.x_count = r_x_count;
   assign bus.y_count = r_y_count;
`endif
endmodule
